// File: rtl/ibex_rf_ckpt_pkg.sv
// ibex_rf_ckpt_pkg: shared FSM state type and ring-pointer helpers for the checkpointed register file
// Contents: ckpt_state_e (IDLE/RESTORE), ptr_width/cnt_width sizing helpers,
//           ring_next/ring_prev modulo pointer arithmetic over the checkpoint ring.
package ibex_rf_ckpt_pkg;

    typedef enum logic {
        IDLE,
        RESTORE
    } ckpt_state_e;

    // Slot pointer width; a single-slot ring still needs one bit for a legal port.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold 0..n valid checkpoints.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    function automatic int unsigned ring_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

    // Slot that is depth entries older than the newest one (the newest sits at idx-1).
    function automatic int unsigned ring_prev(input int unsigned idx, input int unsigned depth,
                                              input int unsigned n);
        return (idx + n - 1 - depth) % n;
    endfunction

endpackage

// File: rtl/ibex_register_file_ckpt_ff_ctrl.sv
// ibex_rf_ckpt_ctrl: backup scheduling and rollback control for the checkpointed register file
// Ports: clk, rst_n        clock, synchronous active-low reset
//        interval          cycles between periodic backups (0 = none)
//        ckpt_req          forced backup request
//        mismatch, depth   rollback request and how many checkpoints back
//        backup            snapshot rf into slot head this cycle
//        restore           load rf from slot target this cycle
//        restore_fail      pulse after a rollback request with no valid checkpoint
//        ckpt_cnt          number of valid checkpoints
//        head, target      ring slot to write on backup / to read on restore
module ibex_rf_ckpt_ctrl
    import ibex_rf_ckpt_pkg::*;
#(
    parameter int unsigned NumCheckpoints = 2,
    parameter int unsigned IntervalWidth  = 5,
    localparam int unsigned PW = ptr_width(NumCheckpoints),
    localparam int unsigned CW = cnt_width(NumCheckpoints)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IntervalWidth-1:0] interval,
    input  logic                     ckpt_req,
    input  logic                     mismatch,
    input  logic [PW-1:0]            depth,
    output logic                     backup,
    output logic                     restore,
    output logic                     restore_fail,
    output logic [CW-1:0]            ckpt_cnt,
    output logic [PW-1:0]            head,
    output logic [PW-1:0]            target
);

    ckpt_state_e              state_q, state_d;
    logic [IntervalWidth-1:0] cnt_q, cnt_d;
    logic [PW-1:0]            head_q, head_d, target_q, target_d, depth_q, depth_d;
    logic [CW-1:0]            ckpt_q, ckpt_d;
    logic                     fail_q, fail_d;
    logic                     idle, accept;

    always_comb begin
        idle     = state_q == IDLE;
        accept   = idle && mismatch && (32'(depth) < 32'(ckpt_q));
        backup   = idle && !mismatch && (ckpt_req || (interval != '0 && cnt_q == interval));
        restore  = !idle;
        state_d  = accept ? RESTORE : IDLE;
        // Counter only runs in IDLE while no rollback is requested; a rejected rollback holds it.
        cnt_d    = (backup || accept) ? '0 :
                   (idle && !mismatch) ? ((cnt_q >= interval) ? '0 : cnt_q + IntervalWidth'(1)) :
                   cnt_q;
        head_d   = backup  ? PW'(ring_next(32'(head_q), NumCheckpoints)) :
                   restore ? PW'(ring_next(32'(target_q), NumCheckpoints)) :
                   head_q;
        // Rolling back depth slots drops the depth newer snapshots; the target itself stays valid.
        ckpt_d   = backup  ? ((ckpt_q == CW'(NumCheckpoints)) ? ckpt_q : ckpt_q + CW'(1)) :
                   restore ? ckpt_q - CW'(depth_q) :
                   ckpt_q;
        target_d = accept ? PW'(ring_prev(32'(head_q), 32'(depth), NumCheckpoints)) : target_q;
        depth_d  = accept ? depth : depth_q;
        fail_d   = idle && mismatch && !accept;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            head_q   <= '0;
            target_q <= '0;
            depth_q  <= '0;
            ckpt_q   <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            target_q <= target_d;
            depth_q  <= depth_d;
            ckpt_q   <= ckpt_d;
            fail_q   <= fail_d;
        end
    end

    assign restore_fail = fail_q;
    assign ckpt_cnt     = ckpt_q;
    assign head         = head_q;
    assign target       = target_q;

endmodule

// File: rtl/ibex_register_file_ckpt_ff.sv
// ibex_register_file_ckpt_ff: flip-flop RISC-V register file with a ring of rollback checkpoints
// Ports: clk_i, rst_ni                  clock, synchronous active-low reset
//        dummy_instr_id_i/_wb_i         read/write the x0 dummy register (DummyInstructions only)
//        raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o   combinational read ports
//        waddr_a_i, wdata_a_i, we_a_i   write port
//        interval_i, ckpt_req_i         periodic / forced snapshot controls
//        mismatch_i, depth_i            rollback request and checkpoint depth
//        backup_o, restore_o, restore_fail_o, ckpt_cnt_o   checkpoint status
module ibex_register_file_ckpt_ff
    import ibex_rf_ckpt_pkg::*;
#(
    parameter bit                    RV32E             = 1'b0,
    parameter int unsigned           DataWidth         = 32,
    parameter int unsigned           NumCheckpoints    = 2,
    parameter int unsigned           IntervalWidth     = 5,
    parameter bit                    DummyInstructions = 1'b0,
    parameter logic [DataWidth-1:0]  WordZeroVal       = '0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   dummy_instr_id_i,
    input  logic                                   dummy_instr_wb_i,
    input  logic [4:0]                             raddr_a_i,
    output logic [DataWidth-1:0]                   rdata_a_o,
    input  logic [4:0]                             raddr_b_i,
    output logic [DataWidth-1:0]                   rdata_b_o,
    input  logic [4:0]                             waddr_a_i,
    input  logic [DataWidth-1:0]                   wdata_a_i,
    input  logic                                   we_a_i,
    input  logic [IntervalWidth-1:0]               interval_i,
    input  logic                                   ckpt_req_i,
    input  logic                                   mismatch_i,
    input  logic [ptr_width(NumCheckpoints)-1:0]   depth_i,
    output logic                                   backup_o,
    output logic                                   restore_o,
    output logic                                   restore_fail_o,
    output logic [cnt_width(NumCheckpoints)-1:0]   ckpt_cnt_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam int unsigned PW       = ptr_width(NumCheckpoints);

    // rf_q[0] is the dummy x0 register; it only ever leaves reset when DummyInstructions is set.
    logic [DataWidth-1:0] rf_q   [NumWords];
    logic [DataWidth-1:0] slot_q [NumCheckpoints][NumWords-1];
    logic [DataWidth-1:0] words  [32];
    logic [PW-1:0]        head, target;

    ibex_rf_ckpt_ctrl #(
        .NumCheckpoints (NumCheckpoints),
        .IntervalWidth  (IntervalWidth)
    ) u_ctrl (
        .clk          (clk_i),
        .rst_n        (rst_ni),
        .interval     (interval_i),
        .ckpt_req     (ckpt_req_i),
        .mismatch     (mismatch_i),
        .depth        (depth_i),
        .backup       (backup_o),
        .restore      (restore_o),
        .restore_fail (restore_fail_o),
        .ckpt_cnt     (ckpt_cnt_o),
        .head         (head),
        .target       (target)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rf_q <= '{default: WordZeroVal};
        end else begin
            if (restore_o) begin
                for (int s = 0; s < NumCheckpoints; s++)
                    if (target == PW'(s))
                        for (int i = 1; i < NumWords; i++) rf_q[i] <= slot_q[s][i-1];
            end else begin
                for (int i = 1; i < NumWords; i++)
                    if (we_a_i && waddr_a_i == 5'(i)) rf_q[i] <= wdata_a_i;
            end
            if (DummyInstructions && we_a_i && dummy_instr_wb_i && !restore_o) rf_q[0] <= wdata_a_i;
        end
    end

    // Snapshots sample rf_q before this edge's write, so a same-cycle write is excluded.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_q <= '{default: '{default: WordZeroVal}};
        end else if (backup_o) begin
            for (int s = 0; s < NumCheckpoints; s++)
                if (head == PW'(s))
                    for (int i = 1; i < NumWords; i++) slot_q[s][i-1] <= rf_q[i];
        end
    end

    // Addresses beyond the implemented words read as WordZeroVal.
    always_comb begin
        words = '{default: WordZeroVal};
        for (int i = 1; i < NumWords; i++) words[i] = rf_q[i];
        if (DummyInstructions && dummy_instr_id_i) words[0] = rf_q[0];
    end

    assign rdata_a_o = words[raddr_a_i];
    assign rdata_b_o = words[raddr_b_i];

endmodule

// File: doc/ibex_register_file_ckpt_ff.md
Name: ibex_register_file_ckpt_ff

Overview:
- Flip-flop RISC-V register file with 31 (or 15 for RV32E) architectural registers; x0 is hard-wired to zero.
- Keeps a ring of NumCheckpoints snapshots of the whole register file.
- A snapshot is taken periodically (programmable interval) or on request.
- On a lockstep comparator mismatch, the file rolls back to the newest checkpoint or to an older one selected by depth.
- Sits in the ID/WB register-file slot of the core; the rollback controller and comparator connect to the mismatch and status ports.

Parameters:
RV32E, 0, 1 gives 16 words (x0..x15), else 32
DataWidth, 32, register word width
NumCheckpoints, 2, snapshot slots in the ring (>=1)
IntervalWidth, 5, width of interval_i and of the cycle counter
DummyInstructions, 0, 1 makes x0 a dummy-writable register that only dummy instructions can read
WordZeroVal, '0, reset, x0 and cleared-register value

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
dummy_instr_id_i  in  1  read x0 dummy register (DummyInstructions only)
dummy_instr_wb_i  in  1  write x0 dummy register (DummyInstructions only)
raddr_a_i  in  5  read port A address
rdata_a_o  out  DataWidth  read port A data
raddr_b_i  in  5  read port B address
rdata_b_o  out  DataWidth  read port B data
waddr_a_i  in  5  write address
wdata_a_i  in  DataWidth  write data
we_a_i  in  1  write enable
interval_i  in  IntervalWidth  cycles between periodic backups; 0 disables periodic backup
ckpt_req_i  in  1  force a backup this cycle
mismatch_i  in  1  comparator mismatch, requests rollback
depth_i  in  max(1,$clog2(NumCheckpoints))  0 = newest checkpoint, k = k-th older
backup_o  out  1  snapshot captured this cycle
restore_o  out  1  register file loaded from a checkpoint this cycle
restore_fail_o  out  1  one-cycle pulse: rollback rejected
ckpt_cnt_o  out  $clog2(NumCheckpoints+1)  number of valid checkpoints

Behaviour:
- Reset (on a clk_i edge with rst_ni=0):
  - all registers and slots set to WordZeroVal; counter 0; head 0; ckpt_cnt_o 0.
  - FSM goes to IDLE; backup_o, restore_o and restore_fail_o are 0.
  - A reset during RESTORE wins; no load takes place.
- Reads are combinational: rdata = rf[raddr]. x0 reads WordZeroVal unless DummyInstructions && dummy_instr_id_i.
  - An address of 16 or more with RV32E reads WordZeroVal.
- Write: at the edge, rf[waddr] <= wdata when we_a_i and waddr != 0. The write is suppressed in the RESTORE cycle.
- Counter: in IDLE without mismatch_i, cnt increments and wraps at interval_i.
  - It clears on a backup, on entry to RESTORE and on reset.
- Backup condition (combinational backup_o), evaluated in IDLE:
  - (interval_i != 0 && cnt == interval_i) || ckpt_req_i, and mismatch_i == 0.
  - When the condition holds, slot[head] <= pre-write contents of rf at the edge, so a same-cycle write is not in the snapshot.
  - head <= head+1 mod NumCheckpoints; ckpt_cnt <= min(cnt+1, NumCheckpoints). When full, the oldest slot is overwritten.
- FSM states: IDLE, RESTORE.
  - IDLE with mismatch_i=1 and depth_i < ckpt_cnt: latch the target slot (head-1-depth_i) mod NumCheckpoints and go to RESTORE. No backup occurs that cycle.
  - IDLE with mismatch_i=1 and depth_i >= ckpt_cnt: restore_fail_o=1 the next cycle; stay in IDLE; file unchanged.
  - RESTORE (exactly 1 cycle):
    - restore_o=1; all rf words <= target slot at the edge; writes are ignored.
    - head <= target+1; ckpt_cnt <= ckpt_cnt - depth_i, so newer slots are invalidated and the target stays valid.
    - Return to IDLE.
  - mismatch_i and ckpt_req_i are ignored while in RESTORE.
- Latency: mismatch sampled at edge N, restore_o high in cycle N+1, restored data readable in cycle N+2.
- DummyInstructions: the x0 dummy register is written on we_a_i && dummy_instr_wb_i. It is not checkpointed and is unaffected by restore.

Decomposition:
- Package ibex_rf_ckpt_pkg:
  - FSM state enum (IDLE, RESTORE).
  - Functions for the ring pointer arithmetic: prev-slot with modulo, counter width helper.
- Sub-module ibex_rf_ckpt_ctrl:
  - Contains the counter, FSM, head/ckpt_cnt/target pointers and the backup_o, restore_o and restore_fail_o generation.
  - The top level holds the register flops, the slot storage and the read muxes.

Test Plan:
- Periodic backup: interval_i=3, write x5=0xA, let the backup fire, write x5=0xB, pulse mismatch_i with depth 0 -> restore_o one cycle later, then x5 reads 0xA and ckpt_cnt_o=1.
- Same-cycle write: write x7=0x11 in the backup cycle, then rollback -> x7 reads its pre-write value (0) after restore.
- Depth and ring wrap: NumCheckpoints=2, interval_i=0, take snapshots S1 (x1=1), S2 (x1=2) and S3 (x1=3) via ckpt_req_i -> ckpt_cnt_o=2. Rollback depth 1 -> x1=2, ckpt_cnt_o=1.
- Rejected rollback: after reset, mismatch_i with depth 0 -> restore_fail_o pulse, no restore_o, registers unchanged.
- Collisions: mismatch_i together with ckpt_req_i and we_a_i -> no backup, restore_o next cycle. A write during RESTORE to x3=0xFF is dropped. A second mismatch during RESTORE is ignored.
- Reset mid-restore: assert rst_ni=0 in the RESTORE cycle -> all registers 0, ckpt_cnt_o=0, restore_o=0 the next cycle.
